// File: rtl/spi_receive_con.sv
// spi_receive_con
//   Receives pixels from a peripheral FPGA over a 4-line (quad) SPI-like link.
//   Each transfer carries one pixel as two nibbles: the high nibble first, then
//   the low nibble. Each nibble is sampled on a DCLK rising edge. The block
//   assembles the pixel, reports its raster position, and flags frame ends and
//   aborted transfers.
//
// Ports
//   clk_in          system clock (100 MHz)
//   rst_n_in        asynchronous active-low reset
//   chip_data_in    CIPO nibble lines (asynchronous)
//   chip_clk_in     DCLK from the peripheral, idles low (asynchronous)
//   chip_sel_in     CS from the peripheral, active-low (asynchronous)
//   final_pixel_in  high during the transfer of the last pixel of a frame
//   data_out        last assembled pixel {high nibble, low nibble}
//   data_valid_out  one-cycle pulse, data_out newly valid
//   hcount_out      column of the pixel on data_out
//   vcount_out      row of the pixel on data_out
//   frame_done_out  one-cycle pulse with data_valid_out for a final pixel
//   error_out       one-cycle pulse, transfer aborted after one nibble
module spi_receive_con #(
  parameter int DATA_WIDTH = 8,
  parameter int LINES      = 4,
  parameter int H_PIXELS   = 640,
  parameter int V_PIXELS   = 360
) (
  input  logic                  clk_in,
  input  logic                  rst_n_in,
  input  logic [LINES-1:0]      chip_data_in,
  input  logic                  chip_clk_in,
  input  logic                  chip_sel_in,
  input  logic                  final_pixel_in,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  data_valid_out,
  output logic [9:0]            hcount_out,
  output logic [8:0]            vcount_out,
  output logic                  frame_done_out,
  output logic                  error_out
);

  localparam logic [9:0] H_LAST = 10'(H_PIXELS - 1);
  localparam logic [8:0] V_LAST = 9'(V_PIXELS - 1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    HI_NIB  = 2'd1,
    LO_NIB  = 2'd2,
    WAIT_CS = 2'd3
  } state_t;

  logic [LINES-1:0] data_s1_r, data_s2_r, data_d_r;
  logic             dclk_s1_r, dclk_s2_r, dclk_prev_r, rise_r;
  logic             cs_s1_r, cs_s2_r, cs_d_r;
  logic             fin_s1_r, fin_s2_r, fin_d_r;
  logic [2:0]       fill_r;
  logic             armed_r;
  state_t           state_r, state_nx_s;
  logic             capture_hi_s, accept_s, abort_s;
  logic [LINES-1:0] hi_nib_r;
  logic             final_flag_r;
  logic [9:0]       pos_h_r;
  logic [8:0]       pos_v_r;

  // Synchronizers plus one aligned stage: the edge detect is registered, so
  // data, CS and final flag are delayed by the same stage. This keeps them
  // time-aligned with the detected edge, so a CS rise coincident with DCLK
  // is seen together with that edge.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      data_s1_r   <= '0;
      data_s2_r   <= '0;
      data_d_r    <= '0;
      dclk_s1_r   <= 1'b0;
      dclk_s2_r   <= 1'b0;
      dclk_prev_r <= 1'b0;
      rise_r      <= 1'b0;
      cs_s1_r     <= 1'b1;
      cs_s2_r     <= 1'b1;
      cs_d_r      <= 1'b1;
      fin_s1_r    <= 1'b0;
      fin_s2_r    <= 1'b0;
      fin_d_r     <= 1'b0;
    end else begin
      data_s1_r   <= chip_data_in;
      data_s2_r   <= data_s1_r;
      data_d_r    <= data_s2_r;
      dclk_s1_r   <= chip_clk_in;
      dclk_s2_r   <= dclk_s1_r;
      dclk_prev_r <= dclk_s2_r;
      rise_r      <= dclk_s2_r & ~dclk_prev_r;
      cs_s1_r     <= chip_sel_in;
      cs_s2_r     <= cs_s1_r;
      cs_d_r      <= cs_s2_r;
      fin_s1_r    <= final_pixel_in;
      fin_s2_r    <= fin_s1_r;
      fin_d_r     <= fin_s2_r;
    end
  end

  // Arm only after a genuine CS-high has passed through the synchronizers.
  // CS flops reset high, so their output is ignored until the pipe has refilled
  // from the real input; a transfer cut by reset is never joined midway.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      fill_r  <= 3'b000;
      armed_r <= 1'b0;
    end else begin
      fill_r  <= {fill_r[1:0], 1'b1};
      armed_r <= armed_r | (cs_d_r & fill_r[2]);
    end
  end

  // FSM state register
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nx_s;
    end
  end

  // FSM next-state logic; a DCLK edge takes priority over CS in both nibble states
  always_comb begin
    state_nx_s = state_r;
    case (state_r)
      IDLE: begin
        if (!cs_d_r && armed_r) state_nx_s = HI_NIB;
        else                    state_nx_s = IDLE;
      end
      HI_NIB: begin
        if (rise_r)      state_nx_s = LO_NIB;
        else if (cs_d_r) state_nx_s = IDLE;
        else             state_nx_s = HI_NIB;
      end
      LO_NIB: begin
        if (rise_r)      state_nx_s = WAIT_CS;
        else if (cs_d_r) state_nx_s = IDLE;
        else             state_nx_s = LO_NIB;
      end
      WAIT_CS: begin
        if (cs_d_r) state_nx_s = IDLE;
        else        state_nx_s = WAIT_CS;
      end
      default: state_nx_s = IDLE;
    endcase
  end

  // FSM output decode: datapath strobes
  always_comb begin
    capture_hi_s = 1'b0;
    accept_s     = 1'b0;
    abort_s      = 1'b0;
    case (state_r)
      HI_NIB: capture_hi_s = rise_r;
      LO_NIB: begin
        if (rise_r) begin
          accept_s = 1'b1;
        end else begin
          abort_s = cs_d_r;
        end
      end
      default: begin
        capture_hi_s = 1'b0;
        accept_s     = 1'b0;
        abort_s      = 1'b0;
      end
    endcase
  end

  // Pixel assembly, position tracking and registered outputs
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      hi_nib_r       <= '0;
      final_flag_r   <= 1'b0;
      pos_h_r        <= 10'd0;
      pos_v_r        <= 9'd0;
      data_out       <= '0;
      data_valid_out <= 1'b0;
      hcount_out     <= 10'd0;
      vcount_out     <= 9'd0;
      frame_done_out <= 1'b0;
      error_out      <= 1'b0;
    end else begin
      data_valid_out <= accept_s;
      frame_done_out <= accept_s & final_flag_r;
      error_out      <= abort_s;
      if (capture_hi_s) begin
        hi_nib_r     <= data_d_r;
        final_flag_r <= fin_d_r;
      end
      if (accept_s) begin
        data_out   <= {hi_nib_r, data_d_r};
        hcount_out <= pos_h_r;
        vcount_out <= pos_v_r;
        // A final pixel realigns the raster to (0,0) wherever it happened to be
        if (final_flag_r || (pos_h_r == H_LAST && pos_v_r == V_LAST)) begin
          pos_h_r <= 10'd0;
          pos_v_r <= 9'd0;
        end else if (pos_h_r == H_LAST) begin
          pos_h_r <= 10'd0;
          pos_v_r <= pos_v_r + 9'd1;
        end else begin
          pos_h_r <= pos_h_r + 10'd1;
        end
      end
    end
  end

endmodule

// File: tb/tb_spi_receive_con.sv
module tb_spi_receive_con;

  localparam int H = 12;
  localparam int V = 5;

  logic       clk_in = 1'b0;
  logic       rst_n_in;
  logic [3:0] chip_data_in;
  logic       chip_clk_in;
  logic       chip_sel_in;
  logic       final_pixel_in;
  logic [7:0] data_out;
  logic       data_valid_out;
  logic [9:0] hcount_out;
  logic [8:0] vcount_out;
  logic       frame_done_out;
  logic       error_out;

  int checks = 0;
  int failures = 0;
  int valid_seen = 0;

  // reference model: position of the next pixel and last reported pixel
  int pos_h = 0;
  int pos_v = 0;
  int last_data = 0;
  int last_h = 0;
  int last_v = 0;

  spi_receive_con #(
    .DATA_WIDTH(8), .LINES(4), .H_PIXELS(H), .V_PIXELS(V)
  ) dut (
    .clk_in(clk_in), .rst_n_in(rst_n_in), .chip_data_in(chip_data_in),
    .chip_clk_in(chip_clk_in), .chip_sel_in(chip_sel_in),
    .final_pixel_in(final_pixel_in), .data_out(data_out),
    .data_valid_out(data_valid_out), .hcount_out(hcount_out),
    .vcount_out(vcount_out), .frame_done_out(frame_done_out),
    .error_out(error_out)
  );

  always #5 clk_in = ~clk_in;

  always @(negedge clk_in) if (data_valid_out === 1'b1) valid_seen++;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // advance to 1 ns after the next rising clock edge (sample, then drive)
  task automatic step();
    @(posedge clk_in);
    #1;
  endtask

  task automatic chk_quiet(input string tag, input int n);
    for (int k = 0; k < n; k++) begin
      step();
      chk({tag, "_valid"}, 32'(data_valid_out), 32'd0);
      chk({tag, "_err"}, 32'(error_out), 32'd0);
    end
  endtask

  task automatic chk_hold(input string tag);
    chk({tag, "_data"}, 32'(data_out), 32'(last_data));
    chk({tag, "_h"}, 32'(hcount_out), 32'(last_h));
    chk({tag, "_v"}, 32'(vcount_out), 32'(last_v));
  endtask

  // first nibble sent and its DCLK edge returned low
  task automatic first_half(input logic [3:0] hi, input logic fin);
    chip_sel_in = 1'b0;
    repeat (3) step();
    chip_data_in = hi;
    final_pixel_in = fin;
    repeat (2) step();
    chip_clk_in = 1'b1;
    repeat (4) step();
    chip_clk_in = 1'b0;
  endtask

  task automatic send_pixel(input logic [7:0] px, input logic fin, input int extra, input bit cs_with_edge);
    int exp_h;
    int exp_v;
    exp_h = pos_h;
    exp_v = pos_v;
    first_half(px[7:4], fin);
    chip_data_in = px[3:0];
    repeat (3) step();
    chk("pre_edge_valid", 32'(data_valid_out), 32'd0);
    chip_clk_in = 1'b1;
    if (cs_with_edge) chip_sel_in = 1'b1;
    // raw edge captured by stage 1 on the next clock; valid expected 3 clocks later
    for (int k = 1; k <= 4; k++) begin
      step();
      if (k < 4) begin
        chk("latency_early", 32'(data_valid_out), 32'd0);
      end else begin
        chk("valid", 32'(data_valid_out), 32'd1);
        chk("data", 32'(data_out), 32'(px));
        chk("hcount", 32'(hcount_out), 32'(exp_h));
        chk("vcount", 32'(vcount_out), 32'(exp_v));
        chk("frame_done", 32'(frame_done_out), 32'(fin));
        chk("err_on_valid", 32'(error_out), 32'd0);
      end
    end
    step();
    chk("valid_width", 32'(data_valid_out), 32'd0);
    chk("frame_done_width", 32'(frame_done_out), 32'd0);
    last_data = int'(px);
    last_h = exp_h;
    last_v = exp_v;
    if (fin) begin
      pos_h = 0;
      pos_v = 0;
    end else if (pos_h == H - 1) begin
      pos_h = 0;
      pos_v = (pos_v == V - 1) ? 0 : pos_v + 1;
    end else begin
      pos_h = pos_h + 1;
    end
    for (int e = 0; e < extra; e++) begin
      chip_clk_in = 1'b0;
      chk_quiet("extra_lo", 3);
      chip_clk_in = 1'b1;
      chk_quiet("extra_hi", 3);
    end
    chip_clk_in = 1'b0;
    final_pixel_in = 1'b0;
    chip_sel_in = 1'b1;
    chk_quiet("gap", 6);
  endtask

  initial begin
    int base;
    logic [7:0] px;
    rst_n_in = 1'b0;
    chip_data_in = 4'h0;
    chip_clk_in = 1'b0;
    chip_sel_in = 1'b1;
    final_pixel_in = 1'b0;
    repeat (3) step();
    chk("rst_data", 32'(data_out), 32'd0);
    chk("rst_valid", 32'(data_valid_out), 32'd0);
    chk("rst_h", 32'(hcount_out), 32'd0);
    chk("rst_v", 32'(vcount_out), 32'd0);
    chk("rst_fd", 32'(frame_done_out), 32'd0);
    chk("rst_err", 32'(error_out), 32'd0);
    rst_n_in = 1'b1;
    chk_quiet("post_rst", 6);

    // single directed transfer
    send_pixel(8'hA5, 1'b0, 0, 1'b0);

    // CS released before any edge: silent return
    chip_sel_in = 1'b0;
    repeat (4) step();
    chip_sel_in = 1'b1;
    chk_quiet("silent_abort", 8);
    chk_hold("silent_abort");

    // CS released after the first nibble: one error pulse, nothing else
    base = valid_seen;
    first_half(4'h3, 1'b0);
    repeat (3) step();
    chip_sel_in = 1'b1;
    for (int k = 1; k <= 5; k++) begin
      step();
      chk("abort_err", 32'(error_out), (k == 4) ? 32'd1 : 32'd0);
    end
    chk_quiet("abort_after", 4);
    chk("abort_no_valid", 32'(valid_seen - base), 32'd0);
    chk_hold("abort");
    px = 8'($urandom);
    send_pixel(px, 1'b0, 0, 1'b0);

    // extra DCLK edges after the second nibble
    base = valid_seen;
    px = 8'($urandom);
    send_pixel(px, 1'b0, 3, 1'b0);
    chk("extra_count", 32'(valid_seen - base), 32'd1);

    // CS rising together with the second edge: pixel accepted
    px = 8'($urandom);
    send_pixel(px, 1'b0, 0, 1'b1);

    // early final flag at (10,3)
    while (!(pos_h == 10 && pos_v == 3)) begin
      px = 8'($urandom);
      send_pixel(px, 1'b0, 0, 1'b0);
    end
    px = 8'($urandom);
    send_pixel(px, 1'b1, 0, 1'b0);

    // full frame with final flag on the last pixel
    base = valid_seen;
    for (int i = 0; i < H * V; i++) begin
      px = 8'($urandom);
      send_pixel(px, (i == H * V - 1) ? 1'b1 : 1'b0, 0, 1'b0);
    end
    chk("frame_count", 32'(valid_seen - base), 32'(H * V));

    // full frame without final flag: natural wrap to (0,0)
    for (int i = 0; i < H * V + 1; i++) begin
      px = 8'($urandom);
      send_pixel(px, 1'b0, 0, 1'b0);
    end

    // reset between the two edges
    base = valid_seen;
    first_half(4'hC, 1'b0);
    chip_data_in = 4'h6;
    repeat (2) step();
    rst_n_in = 1'b0;
    step();
    chk("midrst_data", 32'(data_out), 32'd0);
    chk("midrst_h", 32'(hcount_out), 32'd0);
    chk("midrst_v", 32'(vcount_out), 32'd0);
    chk("midrst_valid", 32'(data_valid_out), 32'd0);
    rst_n_in = 1'b1;
    repeat (2) step();
    chip_clk_in = 1'b1;
    chk_quiet("midrst_edge", 8);
    chip_clk_in = 1'b0;
    chip_sel_in = 1'b1;
    chk_quiet("midrst_gap", 6);
    chk("midrst_no_valid", 32'(valid_seen - base), 32'd0);
    chk("midrst_hold_data", 32'(data_out), 32'd0);
    pos_h = 0;
    pos_v = 0;
    px = 8'($urandom);
    send_pixel(px, 1'b0, 0, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
